// File: rtl/program_loader_if.sv
// Bundle of the loader's host-side stream, RAM write port, accumulator port and CPU control lines.
// The loader drives through the master modport; the environment (host, RAM, CPU) sits on the slave side.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic [7:0]        acc_data;
  logic              acc_load;
  logic              halt_cpu;
  logic              done;
  logic              err;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_addr, mem_data, mem_we, acc_data, acc_load, halt_cpu, done, err
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_data, mem_we, acc_data, acc_load, halt_cpu, done, err
  );
endinterface

// File: rtl/program_loader.sv
// Programmer-side loader: takes a framed byte stream (length, program bytes, accumulator byte)
// and writes it into program RAM and the accumulator while holding the CPU halted.
module program_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input logic                CLK,
  input logic                RESET,
  program_loader_if.master   bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_ACC,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        acc_data_q, acc_data_d;
  logic              acc_load_q, acc_load_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic rx_ready_c;
  logic accept_c;

  assign rx_ready_c = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_ACC);
  assign accept_c   = rx_ready_c && bus.rx_valid;

  // Next-state and next-output logic; strobes default low so each is a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    waddr_d    = waddr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    acc_data_d = acc_data_q;
    acc_load_d = 1'b0;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          count_d = '0;
          waddr_d = '0;
        end
      end
      S_LEN: begin
        if (accept_c) begin
          if (bus.rx_data == 8'd0) begin
            state_d = S_ACC;
          end else if (32'(bus.rx_data) > DEPTH) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            count_d = CNT_W'(bus.rx_data);
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = waddr_q;
          mem_data_d = bus.rx_data;
          waddr_d    = waddr_q + ADDR_W'(1);
          count_d    = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (accept_c) begin
          acc_data_d = bus.rx_data;
          acc_load_d = 1'b1;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Halt covers the active phases plus the cycle carrying the session's last strobe.
    halt_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_ACC) ||
             mem_we_d || acc_load_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      waddr_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      acc_data_q <= '0;
      acc_load_q <= 1'b0;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      waddr_q    <= waddr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      acc_data_q <= acc_data_d;
      acc_load_q <= acc_load_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_c;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.acc_data = acc_data_q;
  assign bus.acc_load = acc_load_q;
  assign bus.halt_cpu = halt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked every cycle, directed sessions
// with literal expectations, then randomized traffic including resets and stray starts.
module tb_program_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned LW     = ADDR_W + 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  // Frame-level reference: a session is open, the length may have arrived, some data bytes remain.
  logic              m_active, m_have_len, m_done, m_err;
  int                m_left, m_addr;
  logic              e_we, e_ld;
  logic [ADDR_W-1:0] e_ma;
  logic [7:0]        e_md, e_ad;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_active <= 1'b0; m_have_len <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_left <= 0; m_addr <= 0;
      e_we <= 1'b0; e_ld <= 1'b0; e_ma <= '0; e_md <= '0; e_ad <= '0;
    end else begin
      e_we <= 1'b0;
      e_ld <= 1'b0;
      if (!m_active) begin
        if (bus.start) begin
          m_active <= 1'b1; m_have_len <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_addr <= 0;
        end
      end else if (bus.rx_valid) begin
        if (!m_have_len) begin
          if (int'(bus.rx_data) > int'(DEPTH)) begin
            m_active <= 1'b0; m_err <= 1'b1;
          end else begin
            m_have_len <= 1'b1; m_left <= int'(bus.rx_data);
          end
        end else if (m_left > 0) begin
          e_we <= 1'b1; e_ma <= ADDR_W'(m_addr); e_md <= bus.rx_data;
          m_addr <= m_addr + 1; m_left <= m_left - 1;
        end else begin
          e_ld <= 1'b1; e_ad <= bus.rx_data; m_active <= 1'b0; m_done <= 1'b1;
        end
      end
    end
  end

  always @(posedge CLK) cyc_n++;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("rx_ready", 32'(bus.rx_ready), 32'(m_active));
    chk("halt_cpu", 32'(bus.halt_cpu), 32'(m_active | e_we | e_ld));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("err",      32'(bus.err),      32'(m_err));
    chk("mem_we",   32'(bus.mem_we),   32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_ma));
    chk("mem_data", 32'(bus.mem_data), 32'(e_md));
    chk("acc_load", 32'(bus.acc_load), 32'(e_ld));
    chk("acc_data", 32'(bus.acc_data), 32'(e_ad));
    chk("we_ld_excl", 32'(bus.mem_we & bus.acc_load), 32'(0));
  end

  // Observed strobes, used by the directed literal checks.
  logic [LW-1:0] wq[$];
  int            wc[$];
  logic [7:0]    aq[$];
  int            ac[$];

  always @(negedge CLK) begin
    if (bus.mem_we) begin
      wq.push_back({bus.mem_addr, bus.mem_data});
      wc.push_back(cyc_n);
    end
    if (bus.acc_load) begin
      aq.push_back(bus.acc_data);
      ac.push_back(cyc_n);
    end
  end

  task automatic clr_logs();
    wq.delete(); wc.delete(); aq.delete(); ac.delete();
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n  = 0;
    logic ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!ok && n < 20) begin
      #3;
      ok = bus.rx_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'(1));
  endtask

  task automatic chk_write(input int idx, input int addr, input logic [7:0] d);
    if (idx < wq.size()) chk($sformatf("write%0d", idx), 32'(wq[idx]), 32'({ADDR_W'(addr), d}));
    else chk($sformatf("write%0d_missing", idx), 32'(wq.size()), 32'(idx + 1));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    RESET        = 1'b1;
    repeat (3) cyc();
    RESET = 1'b0;
    cyc();

    // Reset state and ignored bytes while idle
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) cyc();
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'(0));
    chk("idle_no_write", 32'(wq.size()), 32'(0));
    bus.rx_valid = 1'b0;
    cyc();

    // Nominal back-to-back session
    clr_logs();
    pulse_start();
    send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'h7E);
    idle(2);
    chk("nom_writes", 32'(wq.size()), 32'(3));
    chk_write(0, 0, 8'hA1); chk_write(1, 1, 8'hB2); chk_write(2, 2, 8'hC3);
    if (wc.size() == 3) chk("nom_consecutive", 32'(wc[2] - wc[0]), 32'(2));
    chk("nom_acc_cnt", 32'(aq.size()), 32'(1));
    if (aq.size() == 1) begin
      chk("nom_acc_data", 32'(aq[0]), 32'h7E);
      if (wc.size() == 3) chk("nom_acc_after_write", 32'(ac[0] - wc[2]), 32'(1));
    end
    chk("nom_done", 32'(bus.done), 32'(1));
    chk("nom_halt", 32'(bus.halt_cpu), 32'(0));

    // Zero-length program
    clr_logs();
    pulse_start();
    send_byte(8'h00); send_byte(8'h42);
    idle(2);
    chk("zero_writes", 32'(wq.size()), 32'(0));
    chk("zero_acc_cnt", 32'(aq.size()), 32'(1));
    if (aq.size() == 1) chk("zero_acc_data", 32'(aq[0]), 32'h42);
    chk("zero_done", 32'(bus.done), 32'(1));

    // Full-depth program
    clr_logs();
    pulse_start();
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 7 + 3));
    send_byte(8'hEE);
    idle(2);
    chk("full_writes", 32'(wq.size()), 32'(16));
    for (int i = 0; i < 16; i++) chk_write(i, i, 8'(i * 7 + 3));
    if (aq.size() == 1) chk("full_acc_data", 32'(aq[0]), 32'hEE);
    chk("full_done", 32'(bus.done), 32'(1));

    // Oversize length
    clr_logs();
    pulse_start();
    send_byte(8'h11);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    repeat (3) cyc();
    bus.rx_valid = 1'b0;
    chk("over_err", 32'(bus.err), 32'(1));
    chk("over_done", 32'(bus.done), 32'(0));
    chk("over_rx_ready", 32'(bus.rx_ready), 32'(0));
    chk("over_strobes", 32'(wq.size() + aq.size()), 32'(0));

    // Gapped stream with a stray start mid-session
    clr_logs();
    pulse_start();
    chk("gap_err_cleared", 32'(bus.err), 32'(0));
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      pulse_start();
      send_byte(8'(8'h31 + i));
    end
    idle(1);
    send_byte(8'h99);
    idle(2);
    chk("gap_writes", 32'(wq.size()), 32'(3));
    for (int i = 0; i < 3; i++) chk_write(i, i, 8'(8'h31 + i));
    if (aq.size() == 1) chk("gap_acc_data", 32'(aq[0]), 32'h99);
    chk("gap_done", 32'(bus.done), 32'(1));

    // Asynchronous reset mid-session, then a one-byte session
    pulse_start();
    send_byte(8'h03); send_byte(8'hD1); send_byte(8'hD2);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("arst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("arst_mem_data", 32'(bus.mem_data), 32'(0));
    chk("arst_halt", 32'(bus.halt_cpu), 32'(0));
    chk("arst_rx_ready", 32'(bus.rx_ready), 32'(0));
    chk("arst_acc_data", 32'(bus.acc_data), 32'(0));
    cyc();
    RESET = 1'b0;
    cyc();
    clr_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h00);
    idle(2);
    chk("post_rst_writes", 32'(wq.size()), 32'(1));
    chk_write(0, 0, 8'h5A);
    chk("post_rst_done", 32'(bus.done), 32'(1));

    // Randomized traffic; the every-cycle compare carries the checking
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(0, 19) == 0);
      bus.rx_valid = ($urandom_range(0, 2) != 0);
      bus.rx_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 18)) : 8'($urandom);
      RESET        = ($urandom_range(0, 499) == 0);
      cyc();
    end
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    RESET        = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Programmer-side master for the CPU's register/memory load interface.
- Accepts a framed byte stream: a length byte, then program bytes written sequentially into program RAM from address 0, then one accumulator preload byte.
- Drives the RAM write port and the accumulator's load/data inputs.
- Holds the CPU in halt while loading and flags completion or a framing error.
- Sits between the host/switch interface and the CPU datapath.

Parameters:
ADDR_W, 4, program RAM address width; RAM depth = 2**ADDR_W bytes.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
start  in  1  begin a load session; sampled high for one or more cycles.
rx_data  in  8  stream byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  loader can accept a byte this cycle.
mem_addr  out  ADDR_W  RAM write address.
mem_data  out  8  RAM write data.
mem_we  out  1  RAM write strobe, one cycle per byte.
acc_data  out  8  accumulator preload value.
acc_load  out  1  accumulator load strobe, one-cycle pulse.
halt_cpu  out  1  hold CPU while a session is active.
done  out  1  session completed successfully.
err  out  1  length byte out of range.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state=IDLE; all outputs 0, including mem_addr, mem_data, acc_data and count.
- Reset mid-session aborts immediately. No partial strobe is issued after RESET asserts.
- Byte accept: a byte is taken on a rising edge where rx_valid & rx_ready. One byte per cycle max; back-to-back accepts are supported.
- rx_ready = 1 only in LEN, DATA and ACC. It is combinational from state and does not depend on rx_valid.
- halt_cpu = 1 in LEN, DATA and ACC, and also on the cycle a final mem_we or acc_load pulse is issued. Otherwise 0.
- IDLE: wait for start. start=1 -> LEN; clear done and err; count=0; next write address = 0.
- LEN: on accept, L = rx_data.
  - L = 0 -> ACC.
  - 1 <= L <= 2**ADDR_W -> DATA with count = L.
  - L > 2**ADDR_W -> ERR.
- DATA: on each accept, the next edge registers mem_we=1, mem_data=rx_data, mem_addr=current write address.
  - Write address then increments, wrapping modulo 2**ADDR_W.
  - count decrements; when count reaches 0 -> ACC.
  - mem_we is a single-cycle pulse per accepted byte, so write latency is 1 cycle after accept.
  - mem_addr and mem_data hold their last values when mem_we=0.
- ACC: on accept, the next edge registers acc_data=rx_data and acc_load=1 for exactly one cycle. State -> DONE.
- DONE: done=1, held. start=1 -> LEN (new session, done cleared the same edge).
- ERR: err=1, held. No RAM or accumulator strobes. start=1 -> LEN.
- start while in LEN/DATA/ACC is ignored.
- rx_valid with rx_ready=0 is ignored (no accept, no side effect).
- mem_we and acc_load are never high in the same cycle.
- With L = 2**ADDR_W, the final write lands at address 2**ADDR_W-1; the next session restarts at 0.
- Width rule: count is ADDR_W+1 bits so that L = 2**ADDR_W is representable.

Test Plan:
- Reset and idle: RESET pulse -> all outputs 0; rx_valid=1 with rx_data=0x55 while IDLE -> no strobes, rx_ready=0.
- Nominal session (ADDR_W=4): start; stream 0x03, 0xA1, 0xB2, 0xC3, 0x7E back-to-back with rx_valid=1.
  - mem_we pulses writing A1@0, B2@1, C3@2 on consecutive cycles.
  - Then acc_load one cycle with acc_data=0x7E.
  - done=1 and halt_cpu=0 thereafter.
- Zero length: start; stream 0x00, 0x42 -> no mem_we; acc_load pulse with acc_data=0x42; done=1.
- Full and oversize length:
  - Length 0x10 plus 16 bytes plus 1 acc byte -> writes to addresses 0..15, then acc_load; done=1.
  - New session with length 0x11 -> err=1, no strobes, rx_ready=0.
- Gapped stream plus ignored start: rx_valid toggled 1/0 during DATA with start pulsed mid-session -> one write per valid byte, addresses contiguous, start has no effect.
- Reset mid-operation: RESET asserted asynchronously after the 2nd of 3 data bytes -> all outputs 0 immediately; subsequent start and length 0x01 write to address 0.
